// File: rtl/spi_dac_streamer.sv
// Sequencer for the AXI4-Lite manager's simple write bus: configures the SPI core for a
// 24-bit DAC, then writes one {CMD_BYTE, sample} word per conv low period.
module spi_dac_streamer #(
  parameter int unsigned           ADDR_WIDTH = 14,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] SIZE_ADDR  = ADDR_WIDTH'(14'h1080),
  parameter logic [ADDR_WIDTH-1:0] DELAY_ADDR = ADDR_WIDTH'(14'h1010),
  parameter logic [ADDR_WIDTH-1:0] EN_ADDR    = ADDR_WIDTH'(14'h1500),
  parameter logic [ADDR_WIDTH-1:0] TX_ADDR    = ADDR_WIDTH'(14'h1400),
  parameter int unsigned           FRAME_BITS = 24,
  parameter int unsigned           INIT_DELAY = 600,
  parameter logic [7:0]            CMD_BYTE   = 8'h30
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  s_valid,
  input  logic [15:0]           s_data,
  output logic                  s_ready,
  input  logic                  conv,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [DATA_WIDTH-1:0] wrData,
  output logic                  wr,
  input  logic                  wrDone,
  output logic                  busy,
  output logic [31:0]           frames,
  output logic [15:0]           underruns
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_SIZE,
    S_CFG_DELAY,
    S_CFG_EN,
    S_WAIT_LO,
    S_FETCH,
    S_SEND,
    S_WAIT_HI
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_conv_m, r_conv_s;
  logic                  r_wr, w_wr_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nxt;
  logic                  r_busy;
  logic [31:0]           r_frames, w_frames_nxt;
  logic [15:0]           r_underruns, w_underruns_nxt;
  logic                  r_stop_pend, w_stop_pend_nxt;
  logic                  w_stop_any;
  logic                  w_wr_ack;
  logic [ADDR_WIDTH-1:0] w_cfg_addr;
  logic [DATA_WIDTH-1:0] w_cfg_data;
  state_t                w_cfg_next;

  // conv comes from another block's timing; synchronise before use (idle high)
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_conv_m <= 1'b1;
      r_conv_s <= 1'b1;
    end else begin
      r_conv_m <= conv;
      r_conv_s <= r_conv_m;
    end
  end

  assign w_stop_any = r_stop_pend | stop;
  assign w_wr_ack   = r_wr & wrDone;

  // Address/data/successor for whichever configuration write is current
  always_comb begin
    w_cfg_addr = EN_ADDR;
    w_cfg_data = DATA_WIDTH'(1);
    w_cfg_next = S_WAIT_LO;
    case (r_state)
      S_CFG_SIZE: begin
        w_cfg_addr = SIZE_ADDR;
        w_cfg_data = DATA_WIDTH'(FRAME_BITS);
        w_cfg_next = S_CFG_DELAY;
      end
      S_CFG_DELAY: begin
        w_cfg_addr = DELAY_ADDR;
        w_cfg_data = DATA_WIDTH'(INIT_DELAY);
        w_cfg_next = S_CFG_EN;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wr_nxt        = r_wr;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_frames_nxt    = r_frames;
    w_underruns_nxt = r_underruns;
    w_stop_pend_nxt = w_stop_any;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt     = S_CFG_SIZE;
          w_frames_nxt    = '0;
          w_underruns_nxt = '0;
        end
      end
      S_CFG_SIZE, S_CFG_DELAY, S_CFG_EN: begin
        // wr is low on entry, so a low wr here means this write is not issued yet
        if (w_wr_ack) begin
          w_wr_nxt    = 1'b0;
          w_state_nxt = w_stop_any ? S_IDLE : w_cfg_next;
        end else if (!r_wr) begin
          if (w_stop_any) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_wr_nxt      = 1'b1;
            w_wr_addr_nxt = w_cfg_addr;
            w_wr_data_nxt = w_cfg_data;
          end
        end
      end
      S_WAIT_LO: begin
        if (w_stop_any)     w_state_nxt = S_IDLE;
        else if (!r_conv_s) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (s_valid) begin
          w_wr_nxt      = 1'b1;
          w_wr_addr_nxt = TX_ADDR;
          w_wr_data_nxt = DATA_WIDTH'({CMD_BYTE, s_data});
          w_state_nxt   = S_SEND;
        end else begin
          if (r_underruns != 16'hFFFF) w_underruns_nxt = r_underruns + 16'd1;
          w_state_nxt = S_WAIT_HI;
        end
      end
      S_SEND: begin
        if (w_wr_ack) begin
          w_wr_nxt     = 1'b0;
          w_frames_nxt = r_frames + 32'd1;
          w_state_nxt  = w_stop_any ? S_IDLE : S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (w_stop_any)    w_state_nxt = S_IDLE;
        else if (r_conv_s) w_state_nxt = S_WAIT_LO;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_IDLE) w_stop_pend_nxt = 1'b0;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_frames    <= '0;
      r_underruns <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr        <= w_wr_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_frames    <= w_frames_nxt;
      r_underruns <= w_underruns_nxt;
      r_stop_pend <= w_stop_pend_nxt;
    end
  end

  // Ready only during the single FETCH cycle, so at most one sample per frame
  assign s_ready   = (r_state == S_FETCH) & s_valid;
  assign wr        = r_wr;
  assign wrAddr    = r_wr_addr;
  assign wrData    = r_wr_data;
  assign busy      = r_busy;
  assign frames    = r_frames;
  assign underruns = r_underruns;

endmodule

// File: tb/tb_spi_dac_streamer.sv
// Directed bench for spi_dac_streamer: simple-bus manager model with fixed write latency,
// conv frame generator, per-frame vector table, and stop/reset/streaming sequences.
module tb_spi_dac_streamer;

  localparam int LAT     = 2;
  localparam int LOW     = 12;
  localparam int HIGH    = 8;
  localparam int NSTREAM = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        conv = 1'b1;
  logic        wrDone;
  logic        s_ready;
  logic        wr;
  logic        busy;
  logic [13:0] wrAddr;
  logic [31:0] wrData;
  logic [31:0] frames;
  logic [15:0] underruns;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          viol    = 0;
  bit          hs_en   = 1'b1;
  logic [13:0] wl_addr[$];
  logic [31:0] wl_data[$];

  spi_dac_streamer dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .start       (start),
    .stop        (stop),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .conv        (conv),
    .wrAddr      (wrAddr),
    .wrData      (wrData),
    .wr          (wr),
    .wrDone      (wrDone),
    .busy        (busy),
    .frames      (frames),
    .underruns   (underruns)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Manager model: completes each write LAT cycles after wr rises and logs it;
  // also watches the handshake rules (stable while wr, hold until done, gap after done).
  initial begin
    int          cnt;
    bit          p_wr;
    bit          d;
    logic [13:0] p_addr;
    logic [31:0] p_data;
    wrDone = 1'b0;
    cnt    = 0;
    p_wr   = 1'b0;
    p_addr = '0;
    p_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wrDone = 1'b0;
        cnt    = 0;
        p_wr   = 1'b0;
      end else begin
        d = wrDone;
        if (hs_en && p_wr) begin
          if (d && wr) viol++;
          if (!d && !wr) viol++;
          if (!d && wr && (wrAddr != p_addr || wrData != p_data)) viol++;
        end
        if (d) begin
          wrDone = 1'b0;
        end else if (wr) begin
          cnt++;
          if (cnt >= LAT) begin
            wrDone = 1'b1;
            cnt    = 0;
            wl_addr.push_back(wrAddr);
            wl_data.push_back(wrData);
          end
        end else begin
          cnt = 0;
        end
        p_wr   = wr;
        p_addr = wrAddr;
        p_data = wrData;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One conv low/high period; counts s_ready cycles and the step at which wr first rose.
  task automatic do_frame(output int rdy, output int lat);
    rdy  = 0;
    lat  = -1;
    conv = 1'b0;
    for (int i = 1; i <= LOW; i++) begin
      step();
      if (s_ready) rdy++;
      if (wr && lat < 0) lat = i;
    end
    conv = 1'b1;
    for (int i = 0; i < HIGH; i++) begin
      step();
      if (s_ready) rdy++;
    end
  endtask

  task automatic run_config(input string tag);
    int n0;
    n0    = wl_addr.size();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 60 && wl_addr.size() < n0 + 3; i++) step();
    step();
    step();
    check({tag, "_nwr"}, 32'(wl_addr.size() - n0), 32'd3);
    if (wl_addr.size() >= n0 + 3) begin
      check({tag, "_a0"}, 32'(wl_addr[n0]),     32'h1080);
      check({tag, "_d0"}, wl_data[n0],          32'd24);
      check({tag, "_a1"}, 32'(wl_addr[n0 + 1]), 32'h1010);
      check({tag, "_d1"}, wl_data[n0 + 1],      32'd600);
      check({tag, "_a2"}, 32'(wl_addr[n0 + 2]), 32'h1500);
      check({tag, "_d2"}, wl_data[n0 + 2],      32'd1);
    end
    check({tag, "_busy"},   32'(busy),      32'd1);
    check({tag, "_frames"}, frames,         32'd0);
    check({tag, "_und"},    32'(underruns), 32'd0);
  endtask

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        exp_wr;
    logic [31:0] exp_frames;
    logic [15:0] exp_und;
    int          exp_rdy;
  } vec_t;

  initial begin
    vec_t        vt[8];
    int          rdy;
    int          lat;
    int          n0;
    int          mism;
    logic [15:0] samp;
    logic [15:0] exp_q[$];

    vt[0] = '{1'b1, 16'hABCD, 1'b1, 32'd1, 16'd0, 1};
    vt[1] = '{1'b0, 16'h0000, 1'b0, 32'd1, 16'd1, 0};
    vt[2] = '{1'b1, 16'h0000, 1'b1, 32'd2, 16'd1, 1};
    vt[3] = '{1'b1, 16'hFFFF, 1'b1, 32'd3, 16'd1, 1};
    vt[4] = '{1'b0, 16'h1111, 1'b0, 32'd3, 16'd2, 0};
    vt[5] = '{1'b0, 16'h2222, 1'b0, 32'd3, 16'd3, 0};
    vt[6] = '{1'b1, 16'h1234, 1'b1, 32'd4, 16'd3, 1};
    vt[7] = '{1'b1, 16'h8001, 1'b1, 32'd5, 16'd3, 1};

    // Reset state
    repeat (3) step();
    check("rst_wr",     32'(wr),        32'd0);
    check("rst_addr",   32'(wrAddr),    32'd0);
    check("rst_data",   wrData,         32'd0);
    check("rst_ready",  32'(s_ready),   32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_frames", frames,         32'd0);
    check("rst_und",    32'(underruns), 32'd0);
    rst = 1'b0;
    step();

    run_config("cfg1");

    // Per-frame vectors: data frames, underruns, boundary sample values
    foreach (vt[k]) begin
      s_valid = vt[k].valid;
      s_data  = vt[k].data;
      n0      = wl_addr.size();
      do_frame(rdy, lat);
      check($sformatf("v%0d_nwr", k), 32'(wl_addr.size() - n0), 32'(vt[k].exp_wr));
      if (vt[k].exp_wr && wl_addr.size() > n0) begin
        check($sformatf("v%0d_addr", k), 32'(wl_addr[n0]), 32'h1400);
        check($sformatf("v%0d_data", k), wl_data[n0], {16'h0030, vt[k].data});
        check($sformatf("v%0d_lat", k), 32'(lat), 32'd4);
      end
      check($sformatf("v%0d_ready", k),  32'(rdy),       32'(vt[k].exp_rdy));
      check($sformatf("v%0d_frames", k), frames,         vt[k].exp_frames);
      check($sformatf("v%0d_und", k),    32'(underruns), 32'(vt[k].exp_und));
    end

    // stop while wr=1: write completes, then IDLE
    s_valid = 1'b1;
    s_data  = 16'h5A5A;
    n0      = wl_addr.size();
    conv    = 1'b0;
    for (int i = 0; i < 10 && !wr; i++) step();
    check("stop_wr_up", 32'(wr), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (4) step();
    check("stop_nwr",    32'(wl_addr.size() - n0), 32'd1);
    if (wl_addr.size() > n0) check("stop_data", wl_data[n0], 32'h00305A5A);
    check("stop_busy",   32'(busy), 32'd0);
    check("stop_wr",     32'(wr),   32'd0);
    check("stop_frames", frames,    32'd6);
    conv = 1'b1;
    repeat (4) step();
    n0 = wl_addr.size();
    do_frame(rdy, lat);
    check("idle_ready", 32'(rdy),                  32'd0);
    check("idle_nwr",   32'(wl_addr.size() - n0),  32'd0);

    // start and stop together in IDLE: stop wins, counters untouched
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) step();
    check("ss_busy",   32'(busy),                 32'd0);
    check("ss_nwr",    32'(wl_addr.size() - n0),  32'd0);
    check("ss_frames", frames,                    32'd6);

    // Re-start (clears counters) and stream samples in order
    run_config("cfg2");
    n0 = wl_addr.size();
    s_valid = 1'b1;
    for (int i = 0; i < NSTREAM; i++) begin
      samp   = 16'((i * 40503 + 7) & 32'hFFFF);
      s_data = samp;
      exp_q.push_back(samp);
      do_frame(rdy, lat);
    end
    check("stream_nwr", 32'(wl_addr.size() - n0), 32'(NSTREAM));
    mism = 0;
    for (int i = 0; i < NSTREAM && n0 + i < wl_addr.size(); i++) begin
      if (wl_addr[n0 + i] != 14'h1400 || wl_data[n0 + i] != {16'h0030, exp_q[i]}) mism++;
    end
    check("stream_words",  32'(mism),      32'd0);
    check("stream_frames", frames,         32'(NSTREAM));
    check("stream_und",    32'(underruns), 32'd0);

    // Reset while wr=1: wr drops at once, counters clear, full config again
    s_data = 16'h7777;
    n0     = wl_addr.size();
    conv   = 1'b0;
    for (int i = 0; i < 10 && !wr; i++) step();
    check("arst_wr_up", 32'(wr), 32'd1);
    hs_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_wr",     32'(wr),        32'd0);
    check("arst_addr",   32'(wrAddr),    32'd0);
    check("arst_busy",   32'(busy),      32'd0);
    check("arst_frames", frames,         32'd0);
    check("arst_und",    32'(underruns), 32'd0);
    step();
    rst     = 1'b0;
    conv    = 1'b1;
    s_valid = 1'b0;
    step();
    step();
    hs_en = 1'b1;
    check("arst_nwr", 32'(wl_addr.size() - n0), 32'd0);
    run_config("cfg3");

    check("handshake_viol", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
